// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared core widths, alignment mask and MEM-stage FSM states
package mem_access_unit_pkg;
  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam logic [2:0] ALIGN_MASK = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_access_unit_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; a bubble clears the bank like reset does
module mem_wb_reg #(
  parameter int XLEN = mem_access_unit_pkg::XLEN,
  parameter int RD_W = mem_access_unit_pkg::RD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_bubble,
  input  logic            i_mem_to_reg,
  input  logic            i_reg_write_en,
  input  logic [RD_W-1:0] i_rd,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic [XLEN-1:0] i_read_data,
  output logic            o_mem_to_reg,
  output logic            o_reg_write_en,
  output logic [RD_W-1:0] o_rd,
  output logic [XLEN-1:0] o_alu_out,
  output logic [XLEN-1:0] o_read_data
);
  always_ff @(posedge clk)
    if (!reset || i_bubble) begin
      o_mem_to_reg   <= 1'b0;
      o_reg_write_en <= 1'b0;
      o_rd           <= '0;
      o_alu_out      <= '0;
      o_read_data    <= '0;
    end else begin
      o_mem_to_reg   <= i_mem_to_reg;
      o_reg_write_en <= i_reg_write_en;
      o_rd           <= i_rd;
      o_alu_out      <= i_alu_out;
      o_read_data    <= i_read_data;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with req/ready data-memory handshake and MEM/WB register
module mem_access_unit #(
  parameter int XLEN = mem_access_unit_pkg::XLEN,
  parameter int RD_W = mem_access_unit_pkg::RD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_to_reg,
  input  logic            reg_write_en,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] data,
  input  logic [RD_W-1:0] rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            mem_err,
  output logic            mem_to_reg_out,
  output logic            reg_write_en_out,
  output logic [RD_W-1:0] rd_out,
  output logic [XLEN-1:0] alu_out_out,
  output logic [XLEN-1:0] read_data_out
);
  import mem_access_unit_pkg::*;
  state_t r_state, w_next;
  logic r_req, r_we, r_mem_err;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic w_acc, w_aligned, w_load, w_issue, w_mis, w_done;
  assign w_acc     = mem_read | mem_write;
  assign w_aligned = (alu_out[2:0] & ALIGN_MASK) == 3'b000;
  assign w_load    = mem_read & ~mem_write;
  always_comb begin
    w_issue = (r_state == IDLE) & w_acc & w_aligned;
    w_mis   = (r_state == IDLE) & w_acc & ~w_aligned;
    w_done  = (r_state == WAIT) & dmem_ready;
    stall   = w_issue | (r_state == WAIT);
    w_next  = (w_issue || (r_state == WAIT && !dmem_ready)) ? WAIT : w_done ? DONE : IDLE;
  end
  // DONE always falls back to IDLE without looking at acc, so the held instruction never re-issues
  always_ff @(posedge clk)
    if (!reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_err <= w_mis;
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= mem_write;
        r_addr  <= alu_out;
        r_wdata <= data;
      end else if (w_done) r_req <= 1'b0;
      if (w_done && !r_we) r_rdata <= dmem_rdata;
    end
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_mem_err;
  mem_wb_reg #(.XLEN(XLEN), .RD_W(RD_W)) u_wb (
    .clk            (clk),
    .reset          (reset),
    .i_bubble       (stall | w_mis),
    .i_mem_to_reg   (mem_to_reg),
    .i_reg_write_en (reg_write_en),
    .i_rd           (rd),
    .i_alu_out      (alu_out),
    .i_read_data    (w_load ? r_rdata : '0),
    .o_mem_to_reg   (mem_to_reg_out),
    .o_reg_write_en (reg_write_en_out),
    .o_rd           (rd_out),
    .o_alu_out      (alu_out_out),
    .o_read_data    (read_data_out)
  );
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit plus MEM/WB pipeline register for the 5-stage 64-bit RISC-V core. It consumes the EX/MEM register outputs and runs a req/ready handshake with a variable-latency data memory. It raises a pipeline stall while an access is outstanding and delivers registered write-back fields to the WB stage.

## Interface
Parameters:
- XLEN, 64, address/data width
- RD_W, 5, destination register index width

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- mem_to_reg  in  1  EX/MEM: write-back selects memory data
- reg_write_en  in  1  EX/MEM: instruction writes rd
- mem_read  in  1  EX/MEM: load
- mem_write  in  1  EX/MEM: store
- alu_out  in  XLEN  EX/MEM: ALU result / effective address
- data  in  XLEN  EX/MEM: store data
- rd  in  RD_W  EX/MEM: destination register
- dmem_req  out  1  memory request valid (registered)
- dmem_we  out  1  1 = store, 0 = load (registered)
- dmem_addr  out  XLEN  request address (registered)
- dmem_wdata  out  XLEN  store data (registered)
- dmem_ready  in  1  memory completes the current request this cycle
- dmem_rdata  in  XLEN  load data, valid when dmem_ready=1 and dmem_we=0
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- mem_err  out  1  one-cycle pulse: misaligned access dropped
- mem_to_reg_out  out  1  WB: select read_data_out
- reg_write_en_out  out  1  WB: register write enable
- rd_out  out  RD_W  WB: destination register
- alu_out_out  out  XLEN  WB: ALU result
- read_data_out  out  XLEN  WB: loaded data; 0 for non-loads

## Operation
- Access condition: acc = mem_read | mem_write. Alignment: aligned = (alu_out[2:0] == 0), doubleword only.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - acc & aligned: latch dmem_addr=alu_out, dmem_wdata=data, dmem_we=mem_write; set dmem_req=1; go to WAIT.
  - acc & !aligned: no request; mem_err=1 next cycle; WB gets a bubble.
  - no acc: pass the instruction to WB.
- WAIT: hold dmem_req/we/addr/wdata stable. When dmem_ready=1: capture dmem_rdata if load, clear dmem_req next edge, go to DONE.
- DONE: stall=0; the held EX/MEM instruction retires to WB at this edge. Go to IDLE unconditionally; acc is not re-evaluated here, so there is no double issue.
- stall = (IDLE & acc & aligned) | WAIT.
- WB register update, every edge:
  - stall=1 or misaligned: bubble (reg_write_en_out=0, mem_to_reg_out=0, others don't-care but driven 0).
  - otherwise: load the EX/MEM fields. read_data_out = captured rdata for loads, 0 otherwise.
- mem_read & mem_write both high: treated as a store.

## Timing
- Reset (reset=0 at an edge): state IDLE; dmem_req, dmem_we, stall-relevant state, mem_err, and all WB outputs = 0; dmem_addr/wdata = 0.
- Non-memory instruction: 1-cycle latency to WB outputs, like a plain pipeline register.
- Memory access, with N = cycles from dmem_req rising to dmem_ready high (N>=1):
  - stall is high for N+1 cycles (IDLE cycle + N WAIT cycles).
  - DONE cycle follows; WB outputs are valid the cycle after DONE.
  - Minimum total: 3 cycles from EX/MEM presentation to WB.
- dmem_ready is ignored while dmem_req=0.
- Reset mid-WAIT: dmem_req drops at that edge and the request is abandoned. The memory must tolerate a withdrawn request.
- Back-to-back accesses: the second request is issued no earlier than 2 cycles after the first dmem_ready (DONE, then IDLE).

## Structure
- Shared core package: state typedef {IDLE, WAIT, DONE}, XLEN, RD_W, and the ALIGN_MASK = 3'b111 constant.
- Single module. The WB output register bank may be split out as sub-module mem_wb_reg, with inputs, a bubble control, and the same reset behaviour.

## Test plan
- ALU op (reg_write_en=1, rd=5, alu_out=0x2A, no acc) -> next cycle reg_write_en_out=1, rd_out=5, alu_out_out=0x2A, read_data_out=0; stall never high.
- Load from 0x100, dmem_ready after 3 cycles with rdata=0xDEADBEEF -> stall high 4 cycles, dmem_addr=0x100 and dmem_we=0 stable throughout, read_data_out=0xDEADBEEF and mem_to_reg_out=1 the cycle after DONE.
- Store to 0x208 of data=0x1234, ready on first WAIT cycle -> dmem_we=1, dmem_wdata=0x1234, stall 2 cycles, reg_write_en_out=0.
- Load at 0x103 -> no dmem_req, mem_err pulse of 1 cycle, stall=0, reg_write_en_out=0.
- reset=0 asserted during WAIT -> next cycle dmem_req=0, state IDLE, all outputs 0; a later ready pulse has no effect.
- Two consecutive loads (0x10, 0x18) with N=1 -> exactly two requests, no re-issue in DONE, WB data in order.
